// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: stage state enum, occupancy width,
// control bundle field offsets and small helpers.
package pipe_stage_skid_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Control bundle layout (LSB first)
  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_MEMTOREG_BIT = 1;
  localparam int CTRL_MEMREAD_BIT  = 2;
  localparam int CTRL_MEMWRITE_BIT = 3;
  localparam int CTRL_ALUOP_LSB    = 4;
  localparam int CTRL_ALUOP_W      = 4;
  localparam int CTRL_MIN_W        = CTRL_ALUOP_LSB + CTRL_ALUOP_W;

  function automatic logic [OCC_W-1:0] state_occ(
    input skid_state_e s
  );
    logic [OCC_W-1:0] occ;
    occ = '0;
    unique case (s)
      ST_EMPTY: occ = OCC_W'(0);
      ST_MAIN:  occ = OCC_W'(1);
      ST_FULL:  occ = OCC_W'(2);
      default:  occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_buf.sv
// Storage for pipe_stage_skid: main entry (presented) and skid entry.
// Ports: load strobes from the top FSM, flush clears ctrl, main out.
module pipe_skid_buf
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              ld_main_i,
  input  logic              ld_skid_i,
  input  logic              mv_skid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] main_data_o,
  output logic [CTRL_W-1:0] main_ctrl_o
);

  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;

  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      // Data is left as is; only ctrl must read as a bubble.
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      if (ld_main_i) begin
        main_data_d = data_i;
        main_ctrl_d = ctrl_i;
      end else if (mv_skid_i) begin
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
      end
      if (ld_skid_i) begin
        skid_data_d = data_i;
        skid_ctrl_d = ctrl_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign main_data_o = main_data_q;
  assign main_ctrl_o = main_ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with optional two-entry skid buffer (SKID=1).
// Ports: valid/ready/data/ctrl in and out, stall, flush, occupancy.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [OCC_W-1:0]  occ_o
);

  skid_state_e state_q;
  skid_state_e state_d;
  logic        ready_q;
  logic        ready_d;
  logic        push;
  logic        pop;
  logic        ld_main;
  logic        ld_skid;
  logic        mv_skid;
  logic [CTRL_W-1:0] main_ctrl;

  // Stall hides the stage on both sides, so no handshake can fire.
  assign valid_o = (state_q != ST_EMPTY) & ~stall_i;

  // ready_q is 0 in reset and rises one edge after release.
  assign ready_o = (SKID != 0)
                 ? (ready_q & ~stall_i)
                 : (ready_q & ~stall_i & (~valid_o | ready_i));

  assign push = valid_i & ready_o & ~flush_i;
  assign pop  = valid_o & ready_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_MAIN;
            ld_main = 1'b1;
          end
        end
        ST_MAIN: begin
          if (push && pop) begin
            ld_main = 1'b1;
          end else if (push && (SKID != 0)) begin
            state_d = ST_FULL;
            ld_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_MAIN;
            mv_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Registered ready: depends only on next state, never on ready_i.
  assign ready_d = (SKID != 0) ? (state_d != ST_FULL) : 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .ld_main_i   (ld_main),
    .ld_skid_i   (ld_skid),
    .mv_skid_i   (mv_skid),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .main_data_o (data_o),
    .main_ctrl_o (main_ctrl)
  );

  assign ctrl_o = valid_o ? main_ctrl : '0;
  assign occ_o  = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue reference model,
// directed scenarios plus randomized traffic.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [7:0]  ctrl_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [7:0]  ctrl_o;
  logic [1:0]  occ_o;

  pipe_stage_skid #(
    .DATA_W (32),
    .CTRL_W (8),
    .SKID   (1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .ctrl_i  (ctrl_i),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .ctrl_o  (ctrl_o),
    .occ_o   (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
  } word_t;

  word_t q[$];
  bit    rdy_live;
  int    tests;
  int    fails;
  int    popped;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // One cycle: compare DUT against the model, then advance both.
  task automatic step();
    bit e_valid;
    bit e_ready;
    bit do_push;
    bit do_pop;
    word_t w;
    #1;
    e_valid = !stall_i && (q.size() > 0);
    e_ready = rdy_live && !stall_i && (q.size() < 2);
    chk("valid_o", 64'(valid_o), 64'(e_valid));
    chk("ready_o", 64'(ready_o), 64'(e_ready));
    chk("occ_o", 64'(occ_o), 64'(q.size()));
    if (e_valid) begin
      chk("data_o", 64'(data_o), 64'(q[0].d));
      chk("ctrl_o", 64'(ctrl_o), 64'(q[0].c));
    end else begin
      chk("ctrl_bubble", 64'(ctrl_o), 64'd0);
    end
    do_pop  = e_valid && ready_i;
    do_push = e_ready && valid_i;
    w.d = data_i;
    w.c = ctrl_i;
    @(posedge clk);
    rdy_live = 1'b1;
    if (flush_i) begin
      q.delete();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) q.push_back(w);
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] mk_ctrl(input int n);
    logic [7:0] c;
    c = '0;
    c[CTRL_REGWRITE_BIT] = n[0];
    c[CTRL_MEMTOREG_BIT] = n[1];
    c[CTRL_ALUOP_LSB +: CTRL_ALUOP_W] = n[5:2];
    return c;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    popped = 0;
    rdy_live = 1'b0;
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    data_i = '0;
    ctrl_i = '0;

    // Reset state
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_ctrl", 64'(ctrl_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", 64'(ready_o), 64'd0);
    step();
    #1;
    chk("rel_ready_post", 64'(ready_o), 64'd1);

    // Single push, 1-cycle latency
    valid_i = 1'b1;
    data_i = 32'hA5A5_A5A5;
    ctrl_i = 8'h3C;
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    #1;
    chk("lat_valid", 64'(valid_o), 64'd1);
    chk("lat_data", 64'(data_o), 64'hA5A5_A5A5);
    chk("lat_ctrl", 64'(ctrl_o), 64'h3C);
    chk("lat_occ", 64'(occ_o), 64'd1);
    step();

    // Fill to FULL with downstream blocked
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 32'h11;
    ctrl_i = mk_ctrl(1);
    step();
    data_i = 32'h22;
    ctrl_i = mk_ctrl(2);
    step();
    valid_i = 1'b0;
    #1;
    chk("full_occ", 64'(occ_o), 64'd2);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_data", 64'(data_o), 64'h11);

    // Stall while FULL
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", 64'(valid_o), 64'd0);
      chk("stall_ready", 64'(ready_o), 64'd0);
      chk("stall_occ", 64'(occ_o), 64'd2);
      step();
    end
    stall_i = 1'b0;
    #1;
    chk("unstall_valid", 64'(valid_o), 64'd1);
    chk("unstall_data", 64'(data_o), 64'h11);

    // Drain in order
    ready_i = 1'b1;
    step();
    #1;
    chk("drain_data2", 64'(data_o), 64'h22);
    chk("drain_occ", 64'(occ_o), 64'd1);
    step();
    #1;
    chk("drain_empty", 64'(valid_o), 64'd0);

    // Flush while FULL with a simultaneous push
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 32'h33;
    ctrl_i = mk_ctrl(3);
    step();
    data_i = 32'h44;
    ctrl_i = mk_ctrl(4);
    step();
    data_i = 32'h55;
    ctrl_i = mk_ctrl(5);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("flush_occ", 64'(occ_o), 64'd0);
    chk("flush_ctrl", 64'(ctrl_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    ready_i = 1'b1;
    step();
    step();

    // Streaming push+pop with incrementing data
    popped = 0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 101; i++) begin
      data_i = 32'h1000 + 32'(i);
      ctrl_i = mk_ctrl(i);
      valid_i = (i < 100);
      #1;
      if (i > 0) begin
        chk("stream_data", 64'(data_o), 64'h1000 + 64'(i - 1));
        chk("stream_occ", 64'(occ_o), 64'd1);
      end
      step();
    end
    chk("stream_count", 64'(popped), 64'd100);
    valid_i = 1'b0;
    step();

    // Asynchronous reset while FULL
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 32'h66;
    step();
    data_i = 32'h77;
    step();
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd0);
    chk("arst_occ", 64'(occ_o), 64'd0);
    chk("arst_data", 64'(data_o), 64'd0);
    chk("arst_ctrl", 64'(ctrl_o), 64'd0);
    q.delete();
    rdy_live = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_pre", 64'(ready_o), 64'd0);
    step();
    #1;
    chk("arst_rel_post", 64'(ready_o), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 6);
      stall_i = ($urandom_range(0, 9) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      data_i  = $urandom;
      ctrl_i  = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
